// File: rtl/instr_decode_pkg.sv
// Shared RV32I decode types: instruction classes, opcodes, decoded entry
// layout and the output buffer state encoding.
package INSTRUCTION;

  // ILLEGAL must stay at encoding 0 so an all-zero entry reads as illegal.
  typedef enum logic [2:0] {
    ILLEGAL = 3'd0,
    R_TYPE  = 3'd1,
    I_TYPE  = 3'd2,
    S_TYPE  = 3'd3,
    B_TYPE  = 3'd4,
    U_TYPE  = 3'd5,
    J_TYPE  = 3'd6
  } instruction_type;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    instruction_type itype;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [31:0]     imm;
  } decoded_instr_t;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_HALF  = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_t;

endpackage

// File: rtl/instr_decode_field.sv
// Combinational RV32I field extraction: one instruction word in, one
// decoded entry out. Illegal opcodes produce an all-zero entry.
module rv32i_field_decode
  import INSTRUCTION::*;
(
  input  logic [31:0]    instr,
  output decoded_instr_t dec
);

  instruction_type itype;

  // Classify by opcode; anything unlisted (incl. compressed space) is illegal.
  always_comb begin
    itype = ILLEGAL;
    case (instr[6:0])
      OPC_OP:                                       itype = R_TYPE;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_SYSTEM:   itype = I_TYPE;
      OPC_STORE:                                    itype = S_TYPE;
      OPC_BRANCH:                                   itype = B_TYPE;
      OPC_LUI, OPC_AUIPC:                           itype = U_TYPE;
      OPC_JAL:                                      itype = J_TYPE;
      default:                                      itype = ILLEGAL;
    endcase
  end

  // Assemble payload; stores and branches have no destination register.
  always_comb begin
    dec = '0;
    if (itype != ILLEGAL) begin
      dec.itype  = itype;
      dec.rd     = (itype == S_TYPE || itype == B_TYPE) ? 5'd0 : instr[11:7];
      dec.rs1    = instr[19:15];
      dec.rs2    = instr[24:20];
      dec.funct3 = instr[14:12];
      dec.funct7 = instr[31:25];
      case (itype)
        I_TYPE:  dec.imm = {{20{instr[31]}}, instr[31:20]};
        S_TYPE:  dec.imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        B_TYPE:  dec.imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                            instr[11:8], 1'b0};
        U_TYPE:  dec.imm = {instr[31:12], 12'b0};
        J_TYPE:  dec.imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                            instr[30:21], 1'b0};
        default: dec.imm = '0;
      endcase
    end
  end

endmodule

// File: rtl/instr_decode.sv
// Registered RV32I decode stage with a 2-entry skid buffer on the output.
// Intake stops permanently (until reset) once an illegal word is accepted.
module instr_decode
  import INSTRUCTION::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  output logic            out_valid,
  input  logic            out_ready,
  output instruction_type out_type,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [31:0]     out_imm,
  output logic            halted
);

  buf_state_t     state, state_nxt;
  decoded_instr_t dec, main_q, skid_q;
  logic           accept, pop;
  logic           load_main, main_from_skid, load_skid;

  rv32i_field_decode u_field (
    .instr (in_instr),
    .dec   (dec)
  );

  // in_ready depends only on local state, never on out_ready.
  assign in_ready  = (state != BUF_FULL) & ~halted & ~flush & ~reset;
  assign out_valid = (state != BUF_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign out_type   = main_q.itype;
  assign out_rd     = main_q.rd;
  assign out_rs1    = main_q.rs1;
  assign out_rs2    = main_q.rs2;
  assign out_funct3 = main_q.funct3;
  assign out_funct7 = main_q.funct7;
  assign out_imm    = main_q.imm;

  // Buffer state register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= BUF_EMPTY;
    else       state <= state_nxt;
  end

  // Next state and register load controls; flush is applied in the payload block.
  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    case (state)
      BUF_EMPTY: begin
        if (accept) begin
          state_nxt = BUF_HALF;
          load_main = 1'b1;
        end
      end
      BUF_HALF: begin
        if (accept && !pop) begin
          state_nxt = BUF_FULL;
          load_skid = 1'b1;
        end else if (accept && pop) begin
          load_main = 1'b1;
        end else if (pop) begin
          state_nxt = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (pop) begin
          state_nxt      = BUF_HALF;
          load_main      = 1'b1;
          main_from_skid = 1'b1;
        end
      end
      default: state_nxt = BUF_EMPTY;
    endcase
    if (flush) state_nxt = BUF_EMPTY;
  end

  // Main and skid payload registers; flush wipes both.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_main) main_q <= main_from_skid ? skid_q : dec;
      if (load_skid) skid_q <= dec;
    end
  end

  // Sticky halt once an illegal word enters the buffer.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                             halted <= 1'b0;
    else if (accept && dec.itype == ILLEGAL) halted <= 1'b1;
  end

endmodule

// File: tb/tb_instr_decode.sv
// Directed-vector bench for instr_decode. Inputs change and outputs are
// sampled on the falling edge, so each step spans exactly one rising edge.
module tb_instr_decode;
  import INSTRUCTION::*;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = '0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  instruction_type out_type;
  logic [4:0]      out_rd, out_rs1, out_rs2;
  logic [2:0]      out_funct3;
  logic [6:0]      out_funct7;
  logic [31:0]     out_imm;
  logic            halted;

  int vectors = 0;
  int miscompares = 0;

  instr_decode dut (
    .clock(clock), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
    .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm(out_imm),
    .halted(halted)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", out_valid); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted got %b want 0", halted); end
    vectors++; if (out_type !== ILLEGAL) begin miscompares++; $display("FAIL rst_type got %0d want 0", out_type); end
    vectors++; if (out_imm !== 32'h0) begin miscompares++; $display("FAIL rst_imm got %h want 0", out_imm); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    reset = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'h00500093;
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL addi_valid got %b want 1", out_valid); end
    vectors++; if (out_type !== I_TYPE) begin miscompares++; $display("FAIL addi_type got %0d want %0d", out_type, I_TYPE); end
    vectors++; if (out_rd !== 5'd1) begin miscompares++; $display("FAIL addi_rd got %0d want 1", out_rd); end
    vectors++; if (out_rs1 !== 5'd0) begin miscompares++; $display("FAIL addi_rs1 got %0d want 0", out_rs1); end
    vectors++; if (out_imm !== 32'h00000005) begin miscompares++; $display("FAIL addi_imm got %h want 00000005", out_imm); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL addi_drain got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1; in_instr = 32'hFE208EE3;
    step();
    in_instr = 32'h800000EF;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready got %b want 1", in_ready); end
    vectors++; if (out_type !== B_TYPE) begin miscompares++; $display("FAIL beq_type got %0d want %0d", out_type, B_TYPE); end
    vectors++; if (out_imm !== 32'hFFFFFFFC) begin miscompares++; $display("FAIL beq_imm got %h want fffffffc", out_imm); end
    vectors++; if (out_rd !== 5'd0) begin miscompares++; $display("FAIL beq_rd got %0d want 0", out_rd); end
    vectors++; if (out_rs1 !== 5'd1 || out_rs2 !== 5'd2) begin miscompares++; $display("FAIL beq_rs got %0d,%0d want 1,2", out_rs1, out_rs2); end
    vectors++; if (out_funct7 !== 7'h7F) begin miscompares++; $display("FAIL beq_f7 got %h want 7f", out_funct7); end
    step();
    in_valid = 1'b0;
    vectors++; if (out_type !== J_TYPE) begin miscompares++; $display("FAIL jal_type got %0d want %0d", out_type, J_TYPE); end
    vectors++; if (out_imm !== 32'hFFF00000) begin miscompares++; $display("FAIL jal_imm got %h want fff00000", out_imm); end
    vectors++; if (out_rd !== 5'd1) begin miscompares++; $display("FAIL jal_rd got %0d want 1", out_rd); end
    vectors++; if (out_funct7 !== 7'h40) begin miscompares++; $display("FAIL jal_f7 got %h want 40", out_funct7); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093;          // addi x1,x0,1
    step();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_half_ready got %b want 1", in_ready); end
    in_instr = 32'h00200113;                            // addi x2,x0,2
    step();
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_full_ready got %b want 0", in_ready); end
    vectors++; if (out_rd !== 5'd1) begin miscompares++; $display("FAIL bp_hold1 got rd %0d want 1", out_rd); end
    in_instr = 32'h00112223;                            // sw x1,4(x2)
    step();
    vectors++; if (out_rd !== 5'd1 || out_imm !== 32'd1 || out_valid !== 1'b1) begin
      miscompares++; $display("FAIL bp_stable got rd %0d imm %h v %b want 1 1 1", out_rd, out_imm, out_valid); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL bp_still_full got %b want 0", in_ready); end
    out_ready = 1'b1;
    step();
    vectors++; if (out_rd !== 5'd2 || out_imm !== 32'd2) begin miscompares++; $display("FAIL bp_word2 got rd %0d imm %h want 2 2", out_rd, out_imm); end
    step();
    in_valid = 1'b0;
    vectors++; if (out_type !== S_TYPE) begin miscompares++; $display("FAIL bp_word3_type got %0d want %0d", out_type, S_TYPE); end
    vectors++; if (out_imm !== 32'd4 || out_rd !== 5'd0 || out_rs1 !== 5'd2 || out_rs2 !== 5'd1) begin
      miscompares++; $display("FAIL bp_word3 got imm %h rd %0d rs1 %0d rs2 %0d want 4 0 2 1", out_imm, out_rd, out_rs1, out_rs2); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_empty got %b want 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00500093;
    step();
    in_instr = 32'h00200113;
    step();
    in_instr = 32'h00300193;
    flush = 1'b1; out_ready = 1'b1;
    #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_ready got %b want 0", in_ready); end
    step();
    flush = 1'b0; in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %b want 0", out_valid); end
    vectors++; if (out_imm !== 32'h0 || out_type !== ILLEGAL || out_rd !== 5'd0) begin
      miscompares++; $display("FAIL flush_payload got imm %h type %0d rd %0d want 0 0 0", out_imm, out_type, out_rd); end
    #1;
    vectors++; if (in_ready !== 1'b1 || halted !== 1'b0) begin miscompares++; $display("FAIL flush_after got ready %b halted %b want 1 0", in_ready, halted); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_no_replay got %b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00100093;
    step();
    in_instr = 32'hFFFFFFFF;                            // opcode 7f: illegal
    step();
    in_instr = 32'h00200113;
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL ill_halted got %b want 1", halted); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL ill_ready got %b want 0", in_ready); end
    out_ready = 1'b1;
    step();
    vectors++; if (out_valid !== 1'b1 || out_type !== ILLEGAL) begin
      miscompares++; $display("FAIL ill_entry got v %b type %0d want 1 0", out_valid, out_type); end
    vectors++; if (out_imm !== 32'h0 || out_rd !== 5'd0 || out_rs1 !== 5'd0 || out_funct7 !== 7'd0 || out_funct3 !== 3'd0) begin
      miscompares++; $display("FAIL ill_payload got imm %h rd %0d rs1 %0d f7 %h f3 %0d want all 0", out_imm, out_rd, out_rs1, out_funct7, out_funct3); end
    step();
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || halted !== 1'b1) begin
      miscompares++; $display("FAIL ill_drained got v %b ready %b halted %b want 0 0 1", out_valid, in_ready, halted); end
    step();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ill_no_intake got %b want 0", out_valid); end
    in_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    vectors++; if (halted !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_clear_halt got halted %b ready %b want 0 1", halted, in_ready); end
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h00500093;
    step();
    in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL ar_pre got %b want 1", out_valid); end
    #2 reset = 1'b1;
    #1;
    vectors++; if (out_valid !== 1'b0 || out_imm !== 32'h0) begin
      miscompares++; $display("FAIL ar_async got v %b imm %h want 0 0", out_valid, out_imm); end
    step();
    reset = 1'b0;
    step();
    vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++; $display("FAIL ar_after got v %b ready %b want 0 1", out_valid, in_ready); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_illegal();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_decode.md
# instr_decode

Registered RV32I decode stage that sits between instruction fetch and the control FSM/register-file/ALU-buffer datapath. It accepts 32-bit instruction words over a valid/ready handshake and classifies each one into `INSTRUCTION::instruction_type`. It extracts register indices, funct fields and the sign-extended immediate, and presents the result through a 2-entry skid buffer with its own valid/ready handshake. An illegal opcode becomes an `ILLEGAL` (all-zero) entry; the stage then halts intake until reset.

## Interface
Parameters:
- none; widths are fixed by RV32I (XLEN 32, 5-bit register indices).

Ports:
- `clock` in 1: single clock; all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `flush` in 1: synchronous; discards buffered entries.
- `in_valid` in 1: fetch presents `in_instr`.
- `in_ready` out 1: stage accepts `in_instr` this cycle.
- `in_instr` in 32: raw instruction word.
- `out_valid` out 1: decoded entry available.
- `out_ready` in 1: consumer takes the entry this cycle.
- `out_type` out `INSTRUCTION::instruction_type`: decoded class.
- `out_rd`, `out_rs1`, `out_rs2` out 5 each: register indices.
- `out_funct3` out 3; `out_funct7` out 7.
- `out_imm` out 32: sign-extended immediate.
- `halted` out 1: sticky; set once an illegal word has been accepted.

## Operation
- Accept = `in_valid & in_ready`. Pop = `out_valid & out_ready`.
- Opcode `in_instr[6:0]` maps to `out_type` as follows; any other value, including `[1:0] != 2'b11`, maps to `ILLEGAL`:
  - `0110011` → `R_TYPE`.
  - `0010011`, `0000011`, `1100111`, `1110011` → `I_TYPE`.
  - `0100011` → `S_TYPE`.
  - `1100011` → `B_TYPE`.
  - `0110111`, `0010111` → `U_TYPE`.
  - `1101111` → `J_TYPE`.
- Immediate assembly follows the RV32I spec:
  - I: `{20{i[31]}, i[31:20]}`.
  - S: `{20{i[31]}, i[31:25], i[11:7]}`.
  - B: `{19{i[31]}, i[31], i[7], i[30:25], i[11:8], 1'b0}`.
  - U: `{i[31:12], 12'b0}`.
  - J: `{11{i[31]}, i[31], i[19:12], i[20], i[30:21], 1'b0}`.
  - R: 0.
- Field rules:
  - `out_rd` is forced to 0 for S and B.
  - `out_rs1`, `out_rs2`, `out_funct3` and `out_funct7` are raw bit slices.
  - An `ILLEGAL` entry has every payload field forced to 0.
- Buffer state machine, with states EMPTY, HALF and FULL:
  - EMPTY: accept → HALF.
  - HALF: accept without pop → FULL (word goes to skid). Pop without accept → EMPTY. Accept and pop together → HALF, with the main register loaded from the input.
  - FULL: pop → HALF (skid moves to main). No accept is possible in FULL.
- `out_valid` = (state != EMPTY). Outputs are always driven from the main register.
- `in_ready` = (state != FULL) & !halted & !flush. It is forced to 0 while `reset` is high.
- `halted` is set on the cycle after an `ILLEGAL` word is accepted. Once set, `in_ready` stays 0. Already-buffered entries, including the `ILLEGAL` entry, still drain normally. Only `reset` clears `halted`.
- `flush`: on the next edge, state becomes EMPTY and the payload registers are zeroed. `flush` overrides any simultaneous accept or pop, and `halted` is unaffected.

## Timing
- Reset values:
  - state EMPTY.
  - `out_valid` 0 and `halted` 0.
  - all payload outputs 0, with `out_type` = `ILLEGAL`, which is encoding 0.
  - `in_ready` goes to 1 in the first cycle after `reset` deasserts.
- Latency: a word accepted in cycle N appears with `out_valid` = 1 in cycle N+1 if the buffer was EMPTY.
- Throughput: 1 word/cycle while `out_ready` is held at 1. `in_ready` drops only when FULL, so there is no combinational `out_ready` → `in_ready` path.
- Back-pressure: `out_*` remain stable while `out_valid & !out_ready`.
- Reset asserted mid-transfer drops all entries immediately, asynchronously. No partial entry is emitted afterward.

## Structure
- Package `INSTRUCTION` gains the following:
  - `instruction_type` enum with `ILLEGAL = 0`, `R_TYPE`, `I_TYPE`, `S_TYPE`, `B_TYPE`, `U_TYPE`, `J_TYPE`.
  - opcode localparams.
  - packed struct `decoded_instr_t` {type, rd, rs1, rs2, funct3, funct7, imm}.
  - buffer state enum.
- Sub-module `rv32i_field_decode`: purely combinational, word → `decoded_instr_t`, instantiated once at the input. `instr_decode` holds the state machine, the main and skid `decoded_instr_t` registers, and `halted`.

## Test plan
- After reset, hold `out_ready` = 1 and feed `0x00500093` (addi x1,x0,5) → next cycle `out_type`=`I_TYPE`, rd=1, rs1=0, imm=`0x00000005`.
- Feed `0xFE208EE3` (beq x1,x2,-4) then `0x800000EF` (jal x1,-1M) → B entry: imm=`0xFFFFFFFC`, rd=0. J entry: imm=`0xFFF00000`, rd=1.
- Hold `out_ready` = 0 while streaming 3 valid words → after 2 accepts `in_ready`=0 and outputs hold word 1. Release `out_ready` → words 1, 2, 3 emerge in order with no loss or duplicate.
- Accept `0x00000000` followed by valid words → an `ILLEGAL` entry with all-zero payload emerges. `halted`=1 and `in_ready`=0 from the next cycle on. Earlier entries still drain.
- In FULL, assert `flush` and `out_ready` together → next cycle `out_valid`=0 and state is EMPTY. Pulse `reset` mid-stream → `out_valid` drops immediately, asynchronously.
